// File: rtl/tmds_pkg.sv
// tmds_pkg: control-token codes, alignment FSM states and popcount shared by the TMDS decoder.
package tmds_pkg;
    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} fsm_state_t;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        popcount = '0;
        for (int i = 0; i < 8; i++) popcount = popcount + {3'b000, v[i]};
    endfunction
endpackage

// File: rtl/tmds_decoder_if.sv
// tmds_decoder_if: symbol input and decoded output bundle of one TMDS channel decoder.
interface tmds_decoder_if;
    logic       sym_valid_in;
    logic [9:0] sym_in;
    logic       valid_out;
    logic       de_out;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       sym_err_out;
    logic       locked_out;
    logic       bitslip_out;
    logic       disp_err_out;

    modport master (
        output sym_valid_in, sym_in,
        input  valid_out, de_out, data_out, ctrl_out, sym_err_out, locked_out, bitslip_out, disp_err_out
    );
    modport slave (
        input  sym_valid_in, sym_in,
        output valid_out, de_out, data_out, ctrl_out, sym_err_out, locked_out, bitslip_out, disp_err_out
    );
endinterface

// File: rtl/tmds_sym_decode.sv
// tmds_sym_decode: combinational classify, DC-balance un-invert, transition un-XOR and encoder-consistency check.
module tmds_sym_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic       sym_err
);
    logic [7:0] qm;
    logic [3:0] n1;

    assign is_ctrl = sym inside {CTRL_00, CTRL_01, CTRL_10, CTRL_11};
    assign ctrl    = sym == CTRL_01 ? 2'b01 : sym == CTRL_10 ? 2'b10 : sym == CTRL_11 ? 2'b11 : 2'b00;
    assign qm      = sym[9] ? ~sym[7:0] : sym[7:0];
    assign data    = {qm[7:1] ^ qm[6:0] ^ {7{~sym[8]}}, qm[0]};
    assign n1      = popcount(data);
    // The encoder picks XNOR exactly when the byte is ones-heavy, so bit 8 is fully determined by the byte.
    assign sym_err = ~is_ctrl & (sym[8] != ~(n1 > 4'd4 || (n1 == 4'd4 && !data[0])));
endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: 2-stage TMDS channel decoder with word-alignment lock FSM and bitslip requests.
// Define TMDS_DISPARITY_CHECK_EN to add the running-disparity checker on disp_err_out.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned CTRL_RUN       = 8,
    parameter int unsigned SEARCH_TIMEOUT = 1024,
    parameter int unsigned SLIP_WAIT      = 16,
    parameter int unsigned ERR_LIMIT      = 4
) (
    input logic         clk_in,
    input logic         rst_in,
    tmds_decoder_if.slave bus
);
    localparam int RW = $clog2(CTRL_RUN + 1);
    localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SW = $clog2(SLIP_WAIT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(CTRL_RUN);
    localparam logic [TW-1:0] TO_MAX   = TW'(SEARCH_TIMEOUT);
    localparam logic [SW-1:0] SLIP_MAX = SW'(SLIP_WAIT);
    localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);

    logic       s1_valid;
    logic [9:0] s1_sym;
    logic       is_ctrl, sym_err;
    logic [1:0] ctrl;
    logic [7:0] data;

    fsm_state_t    state, state_nx;
    logic [RW-1:0] ctrl_run, ctrl_run_nx;
    logic [TW-1:0] timeout, timeout_nx;
    logic [SW-1:0] slip_cnt, slip_nx;
    logic [EW-1:0] err_cnt, err_nx;
    logic          slip_req;

    tmds_sym_decode u_dec (
        .sym    (s1_sym),
        .is_ctrl(is_ctrl),
        .ctrl   (ctrl),
        .data   (data),
        .sym_err(sym_err)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_sym   <= '0;
        end else begin
            s1_valid <= bus.sym_valid_in;
            if (bus.sym_valid_in) s1_sym <= bus.sym_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.valid_out   <= 1'b0;
            bus.de_out      <= 1'b0;
            bus.data_out    <= '0;
            bus.ctrl_out    <= '0;
            bus.sym_err_out <= 1'b0;
        end else begin
            bus.valid_out <= s1_valid;
            if (s1_valid) begin
                bus.de_out      <= ~is_ctrl;
                bus.data_out    <= is_ctrl ? 8'h00 : data;
                bus.ctrl_out    <= ctrl;
                bus.sym_err_out <= sym_err;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= SEARCH;
            ctrl_run        <= '0;
            timeout         <= '0;
            slip_cnt        <= '0;
            err_cnt         <= '0;
            bus.bitslip_out <= 1'b0;
        end else begin
            state           <= state_nx;
            ctrl_run        <= ctrl_run_nx;
            timeout         <= timeout_nx;
            slip_cnt        <= slip_nx;
            err_cnt         <= err_nx;
            bus.bitslip_out <= slip_req;
        end
    end

    always_comb begin
        state_nx    = state;
        ctrl_run_nx = ctrl_run;
        timeout_nx  = timeout;
        slip_nx     = slip_cnt;
        err_nx      = err_cnt;
        slip_req    = 1'b0;
        if (s1_valid) begin
            if (state == SEARCH) begin
                ctrl_run_nx = is_ctrl ? (ctrl_run == RUN_MAX ? ctrl_run : ctrl_run + RW'(1)) : '0;
                timeout_nx  = timeout == TO_MAX ? timeout : timeout + TW'(1);
                // Lock is checked first so a simultaneous timeout never slips an aligned stream.
                if (ctrl_run_nx == RUN_MAX) begin
                    state_nx    = LOCKED;
                    ctrl_run_nx = '0;
                    timeout_nx  = '0;
                    err_nx      = '0;
                end else if (timeout_nx == TO_MAX) begin
                    state_nx    = SLIP;
                    slip_req    = 1'b1;
                    ctrl_run_nx = '0;
                    timeout_nx  = '0;
                    slip_nx     = '0;
                end
            end else if (state == SLIP) begin
                slip_nx = slip_cnt == SLIP_MAX ? slip_cnt : slip_cnt + SW'(1);
                if (slip_nx == SLIP_MAX) begin
                    state_nx    = SEARCH;
                    slip_nx     = '0;
                    ctrl_run_nx = '0;
                    timeout_nx  = '0;
                end
            end else begin
                err_nx = is_ctrl ? '0 : (sym_err && err_cnt != ERR_MAX) ? err_cnt + EW'(1) : err_cnt;
                if (err_nx == ERR_MAX) begin
                    state_nx    = SEARCH;
                    err_nx      = '0;
                    ctrl_run_nx = '0;
                    timeout_nx  = '0;
                end
            end
        end
    end

    assign bus.locked_out = state == LOCKED;

`ifdef TMDS_DISPARITY_CHECK_EN
    logic signed [4:0] cnt;
    logic signed [5:0] dif, cnt_w, cnt_nx;
    logic [7:0]        qm;
    logic              q8, exp9;

    assign qm = s1_sym[9] ? ~s1_sym[7:0] : s1_sym[7:0];
    assign q8 = s1_sym[8];

    // Replays the transmitter's disparity bookkeeping to predict which way bit 9 had to go.
    always_comb begin
        dif   = $signed({1'b0, popcount(qm), 1'b0}) - 6'sd8;
        cnt_w = {cnt[4], cnt};
        if (cnt == 5'sd0 || dif == 6'sd0) begin
            exp9   = ~q8;
            cnt_nx = cnt_w + (q8 ? dif : -dif);
        end else if ((cnt > 5'sd0 && dif > 6'sd0) || (cnt < 5'sd0 && dif < 6'sd0)) begin
            exp9   = 1'b1;
            cnt_nx = cnt_w + (q8 ? 6'sd2 : 6'sd0) - dif;
        end else begin
            exp9   = 1'b0;
            cnt_nx = cnt_w + dif - (q8 ? 6'sd0 : 6'sd2);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt              <= '0;
            bus.disp_err_out <= 1'b0;
        end else if (s1_valid) begin
            cnt              <= is_ctrl ? 5'sd0 : cnt_nx[4:0];
            bus.disp_err_out <= ~is_ctrl & (s1_sym[9] != exp9);
        end
    end
`else
    assign bus.disp_err_out = 1'b0;
`endif
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed self-checking bench for tmds_decoder (optionally with TMDS_DISPARITY_CHECK_EN).
module tb_tmds_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   enc_cnt = 0;
    logic [13:0] exq[$];
    logic [7:0]  bytes [16] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h10, 8'h3C,
                                8'hC3, 8'h7E, 8'hE7, 8'h12, 8'h34, 8'hF0, 8'h0F, 8'h99};

    always #5 clk = ~clk;

    tmds_decoder_if bus();
    tmds_decoder dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] s);
        bus.sym_valid_in = v;
        bus.sym_in       = s;
        tick();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(1'b0, 10'h0);
        drive(1'b0, 10'h0);
        rst = 1'b0;
    endtask

    // Transmitter-side DVI 8b/10b encoder with its own running disparity.
    task automatic encode(input logic [7:0] din, output logic [9:0] s);
        int n1, n1q;
        logic xn;
        logic [8:0] qm;
        n1 = $countones(din);
        xn = n1 > 4 || (n1 == 4 && !din[0]);
        qm[0] = din[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ din[i]) : (qm[i-1] ^ din[i]);
        qm[8] = ~xn;
        n1q = $countones(qm[7:0]);
        if (enc_cnt == 0 || n1q == 4) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            enc_cnt += qm[8] ? 2 * n1q - 8 : 8 - 2 * n1q;
        end else if ((enc_cnt > 0 && n1q > 4) || (enc_cnt < 0 && n1q < 4)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += 2 * int'(qm[8]) + 8 - 2 * n1q;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            enc_cnt += -2 * int'(!qm[8]) + 2 * n1q - 8;
        end
    endtask

    task automatic observe;
        logic [13:0] e;
        if (bus.valid_out) begin
            if (exq.size() == 0) chk("stream_extra", 32'd1, 32'd0);
            else begin
                e = exq.pop_front();
                if (e[13]) chk("disp_flip", {31'd0, bus.disp_err_out}, {31'd0, e[0]});
                else chk("stream", {19'd0, bus.de_out, bus.data_out, bus.ctrl_out, bus.sym_err_out, bus.disp_err_out},
                         {19'd0, e[12:0]});
            end
        end
    endtask

    task automatic send(input logic [9:0] s, input logic [13:0] e);
        exq.push_back(e);
        drive(1'b1, s);
        observe();
    endtask

    initial begin
        int pulses, at, t;
        logic [9:0] s;
        logic exp_disp;
        bus.sym_valid_in = 1'b0;
        bus.sym_in       = '0;
        do_reset();
        chk("reset_outs", {16'd0, bus.valid_out, bus.de_out, bus.data_out, bus.ctrl_out, bus.sym_err_out,
                           bus.locked_out, bus.bitslip_out, bus.disp_err_out}, 32'd0);

        drive(1'b1, 10'h100);
        chk("lat_valid_early", {31'd0, bus.valid_out}, 32'd0);
        drive(1'b1, 10'h200);
        chk("d100", {20'd0, bus.valid_out, bus.de_out, bus.data_out, bus.sym_err_out, 1'b0}, {20'd0, 12'b1_1_00000000_0_0});
        drive(1'b0, 10'h0);
        chk("d200", {22'd0, bus.de_out, bus.data_out, bus.sym_err_out}, {22'd0, 10'b1_11111111_0});
        drive(1'b0, 10'h0);
        chk("idle_hold", {23'd0, bus.valid_out, bus.data_out}, {23'd0, 9'h0FF});

        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 10'h354);
        chk("lock_after7", {31'd0, bus.locked_out}, 32'd0);
        drive(1'b1, 10'h0AB);
        chk("lock_after8", {31'd0, bus.locked_out}, 32'd1);
        chk("ctrl00", {28'd0, bus.valid_out, bus.de_out, bus.ctrl_out}, {28'd0, 4'b1000});
        drive(1'b0, 10'h0);
        chk("ctrl01", {28'd0, bus.valid_out, bus.de_out, bus.ctrl_out}, {28'd0, 4'b1001});

        drive(1'b1, 10'h1AA);
        drive(1'b1, 10'h1AA);
        chk("d1aa", {22'd0, bus.de_out, bus.data_out, bus.sym_err_out}, {22'd0, 10'b1_11111110_1});
        drive(1'b1, 10'h1AA);
        drive(1'b1, 10'h1AA);
        chk("err3_locked", {31'd0, bus.locked_out}, 32'd1);
        drive(1'b0, 10'h0);
        chk("err4_unlock", {31'd0, bus.locked_out}, 32'd0);

        do_reset();
        pulses = 0;
        at = -1;
        t = 0;
        for (int i = 0; i < 1026; i++) begin
            drive(i < 1024, 10'h100);
            t++;
            if (bus.bitslip_out) begin
                pulses++;
                at = t;
            end
        end
        chk("slip_pulses", pulses, 32'd1);
        chk("slip_time", at, 32'd1025);
        for (int i = 0; i < 23; i++) drive(1'b1, 10'h354);
        drive(1'b0, 10'h0);
        drive(1'b0, 10'h0);
        chk("slip_ignored", {31'd0, bus.locked_out}, 32'd0);
        drive(1'b1, 10'h354);
        drive(1'b0, 10'h0);
        drive(1'b0, 10'h0);
        chk("relock", {30'd0, bus.locked_out, bus.bitslip_out}, 32'd2);

        do_reset();
        exq.delete();
        enc_cnt = 0;
        send(10'h354, {1'b0, 13'b0_00000000_00_0_0});
        for (int i = 0; i < 16; i++) begin
            encode(bytes[i], s);
            send(s, {1'b0, 1'b1, bytes[i], 2'b00, 1'b0, 1'b0});
        end
        enc_cnt = 0;
        send(10'h154, {1'b0, 13'b0_00000000_10_0_0});
        encode(8'h5A, s);
        s[9] = ~s[9];
`ifdef TMDS_DISPARITY_CHECK_EN
        exp_disp = 1'b1;
`else
        exp_disp = 1'b0;
`endif
        send(s, {1'b1, 12'd0, exp_disp});
        enc_cnt = 0;
        send(10'h2AB, {1'b0, 13'b0_00000000_11_0_0});
        drive(1'b0, 10'h0);
        observe();
        drive(1'b0, 10'h0);
        observe();
        chk("queue_empty", exq.size(), 32'd0);

        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 10'h354);
        drive(1'b0, 10'h0);
        drive(1'b0, 10'h0);
        chk("pre_rst_lock", {31'd0, bus.locked_out}, 32'd1);
        drive(1'b1, 10'h100);
        rst = 1'b1;
        drive(1'b1, 10'h200);
        chk("midrst_outs", {16'd0, bus.valid_out, bus.de_out, bus.data_out, bus.ctrl_out, bus.sym_err_out,
                            bus.locked_out, bus.bitslip_out, bus.disp_err_out}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 10'h0);
        chk("flush1", {31'd0, bus.valid_out}, 32'd0);
        drive(1'b0, 10'h0);
        chk("flush2", {23'd0, bus.valid_out, bus.data_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
